operand_fetch_stage: RTL and testbench

- Decode/operand-fetch stage directly upstream of the register file.
- Drives the register-file read addresses and consumes the two read-data buses.
- Resolves RAW hazards by forwarding from EX, MEM and WB, and stalls on load-use hazards.
- Registers a decoded, operand-complete bundle into the ID/EX slot with a valid/ready handshake.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/imm_gen.sv | 39 +++
 rtl/operand_fetch_stage.sv | 156 +++++++++++++++
 tb/tb_operand_fetch_stage.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared RV32I decode constants for the operand-fetch slice: major opcodes,
// register-index width and the per-opcode source-operand usage helpers.
package riscv_pkg;

    localparam int REG_W = 5;
    typedef logic [REG_W-1:0] reg_idx_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // rs1 field carries immediate bits for U/J formats, so it is not a source.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R || opcode == OP_STORE || opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen
// Combinational RV32I immediate extraction, sign-extended to Width.
// Ports:
//   instr_i  instruction word
//   imm_o    immediate for the instruction's format (0 for R-type/unknown)
module imm_gen
    import riscv_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic [31:0]      instr_i,
    output logic [Width-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (instr_i[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            OP_STORE:
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            OP_BRANCH:
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {instr_i[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm_o = Width'($signed(imm32));

endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
// Decode/operand-fetch stage in front of the register file. Drives the RF
// read addresses, resolves RAW hazards by forwarding from EX/MEM/WB, stalls
// on load-use, and registers a complete operand bundle into the ID/EX slot.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_ready/in_instr/in_pc upstream handshake and instruction
//   rr1, rr2 / rd1, rd2              register-file read addresses / data
//   ex_*, mem_*, wb_*                in-flight writers used for forwarding
//   flush                            kill this stage (taken branch/jump)
//   out_valid/out_ready/out_*        ID/EX bundle handshake and fields
module operand_fetch_stage
    import riscv_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [Width-1:0] in_pc,
    output logic [REG_W-1:0] rr1,
    output logic [REG_W-1:0] rr2,
    input  logic [Width-1:0] rd1,
    input  logic [Width-1:0] rd2,
    input  logic             ex_wr_en,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [Width-1:0] ex_result,
    input  logic             mem_wr_en,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [Width-1:0] mem_result,
    input  logic             wb_wr_en,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [Width-1:0] wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_pc,
    output logic [Width-1:0] out_op1,
    output logic [Width-1:0] out_op2,
    output logic [Width-1:0] out_imm,
    output logic [REG_W-1:0] out_rd,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7
);

    logic [6:0]       opcode;
    reg_idx_t         rs1;
    reg_idx_t         rs2;
    logic             use_rs1;
    logic             use_rs2;
    logic             stall;
    logic             advance;
    logic             fire;
    logic [Width-1:0] op1_d;
    logic [Width-1:0] op2_d;
    logic [Width-1:0] imm_d;
    reg_idx_t         rd_d;

    logic             valid_q;
    logic [Width-1:0] pc_q;
    logic [Width-1:0] op1_q;
    logic [Width-1:0] op2_q;
    logic [Width-1:0] imm_q;
    reg_idx_t         rd_q;
    logic [6:0]       opcode_q;
    logic [2:0]       funct3_q;
    logic [6:0]       funct7_q;

    assign opcode  = in_instr[6:0];
    assign rs1     = in_instr[19:15];
    assign rs2     = in_instr[24:20];
    assign rr1     = rs1;
    assign rr2     = rs2;
    assign use_rs1 = uses_rs1(opcode);
    assign use_rs2 = uses_rs2(opcode);

    // Youngest writer wins. A load in EX has no data yet; it is skipped here
    // and the stall below keeps the instruction from being captured.
    // WB is forwarded because the RF write lands after this cycle's read.
    function automatic logic [Width-1:0] fwd(input reg_idx_t rs, input logic used,
                                             input logic [Width-1:0] rf_data);
        if (!used || rs == '0)
            return '0;
        if (ex_wr_en && !ex_is_load && ex_rd == rs)
            return ex_result;
        if (mem_wr_en && mem_rd == rs)
            return mem_result;
        if (wb_wr_en && wb_rd == rs)
            return wb_data;
        return rf_data;
    endfunction

    always_comb begin
        op1_d = fwd(rs1, use_rs1, rd1);
        op2_d = fwd(rs2, use_rs2, rd2);
    end

    assign stall = ex_wr_en && ex_is_load && (ex_rd != '0) &&
                   ((use_rs1 && ex_rd == rs1) || (use_rs2 && ex_rd == rs2));

    assign advance  = !valid_q || out_ready;
    assign in_ready = advance && !stall && !flush && !rst;
    assign fire     = in_valid && in_ready;

    // Stores and branches carry immediate bits in the rd field.
    assign rd_d = (opcode == OP_STORE || opcode == OP_BRANCH) ? '0 : in_instr[11:7];

    imm_gen #(.Width(Width)) u_imm_gen (
        .instr_i (in_instr),
        .imm_o   (imm_d)
    );

    // fire already excludes flush, so flush only needs to drop valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            imm_q    <= '0;
            rd_q     <= '0;
            opcode_q <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
        end else if (flush) begin
            valid_q  <= 1'b0;
        end else if (fire) begin
            valid_q  <= 1'b1;
            pc_q     <= in_pc;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            imm_q    <= imm_d;
            rd_q     <= rd_d;
            opcode_q <= opcode;
            funct3_q <= in_instr[14:12];
            funct7_q <= in_instr[31:25];
        end else if (advance) begin
            valid_q  <= 1'b0;
        end
    end

    assign out_valid  = valid_q;
    assign out_pc     = pc_q;
    assign out_op1    = op1_q;
    assign out_op2    = op2_q;
    assign out_imm    = imm_q;
    assign out_rd     = rd_q;
    assign out_opcode = opcode_q;
    assign out_funct3 = funct3_q;
    assign out_funct7 = funct7_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage
// Directed vector table, hand-written multi-cycle sequences (load-use,
// back-pressure, flush, reset mid-stall) and a randomized phase checked
// against an instruction-level reference model.
module tb_operand_fetch_stage;

    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_IMM    = 7'b0010011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, rd1, rd2;
    logic [4:0]  rr1, rr2;
    logic        ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic [31:0] ex_result, mem_result, wb_data;
    logic [31:0] out_pc, out_op1, out_op2, out_imm;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    operand_fetch_stage #(.Width(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rr1(rr1), .rr2(rr2),
        .rd1(rd1), .rd2(rd2), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_result(ex_result), .mem_wr_en(mem_wr_en),
        .mem_rd(mem_rd), .mem_result(mem_result), .wb_wr_en(wb_wr_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
        .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7(out_funct7)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], T_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], T_BRANCH};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, T_JAL};
    endfunction

    // ---------------- reference model ----------------
    function automatic bit m_uses1(input logic [6:0] op);
        return !(op inside {T_LUI, T_AUIPC, T_JAL});
    endfunction

    function automatic bit m_uses2(input logic [6:0] op);
        return op inside {T_R, T_STORE, T_BRANCH};
    endfunction

    // Immediate as a signed integer built from weighted bit fields.
    function automatic logic [31:0] m_imm(input logic [31:0] ins);
        int hi;
        hi = ins[31] ? -1 : 0;
        case (ins[6:0])
            T_IMM, T_LOAD, T_JALR: return hi * 2048 + int'(ins[30:20]);
            T_STORE:  return hi * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:7]);
            T_BRANCH: return hi * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                             + int'(ins[11:8]) * 2;
            T_LUI, T_AUIPC: return ins & 32'hFFFF_F000;
            T_JAL:    return hi * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                             + int'(ins[30:21]) * 2;
            default:  return 32'd0;
        endcase
    endfunction

    typedef struct {
        bit          en;
        logic [4:0]  rd;
        logic [31:0] d;
    } writer_t;

    // Writers listed youngest first; EX loads have no value to offer.
    function automatic logic [31:0] m_operand(input logic [4:0] rs, input bit used,
                                              input logic [31:0] rf);
        writer_t w[3];
        w[0] = '{en: ex_wr_en && !ex_is_load, rd: ex_rd, d: ex_result};
        w[1] = '{en: mem_wr_en, rd: mem_rd, d: mem_result};
        w[2] = '{en: wb_wr_en, rd: wb_rd, d: wb_data};
        if (!used || rs == 5'd0) return 32'd0;
        foreach (w[i]) if (w[i].en && w[i].rd == rs) return w[i].d;
        return rf;
    endfunction

    function automatic bit m_stall();
        logic [6:0] op;
        op = in_instr[6:0];
        if (!(ex_wr_en && ex_is_load) || ex_rd == 5'd0) return 1'b0;
        return (m_uses1(op) && ex_rd == in_instr[19:15]) ||
               (m_uses2(op) && ex_rd == in_instr[24:20]);
    endfunction

    logic        m_valid;
    logic [31:0] m_pc, m_op1, m_op2, m_imm_q;
    logic [4:0]  m_rd;
    logic [6:0]  m_opc, m_f7;
    logic [2:0]  m_f3;

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9] = '{T_R, T_IMM, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR, T_LUI, T_AUIPC};
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] instr, pc, rd1, rd2;
        logic        ex_wr, ex_ld;
        logic [4:0]  ex_rd;
        logic [31:0] ex_res;
        logic        mem_wr;
        logic [4:0]  mem_rd;
        logic [31:0] mem_res;
        logic        wb_wr;
        logic [4:0]  wb_rd;
        logic [31:0] wb_dat;
        logic [31:0] e_op1, e_op2, e_imm;
        logic [4:0]  e_rd;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] instr, pc, r1, r2,
                                input logic exw, exl, input logic [4:0] exrd, input logic [31:0] exres,
                                input logic mw, input logic [4:0] mrd, input logic [31:0] mres,
                                input logic ww, input logic [4:0] wrd, input logic [31:0] wd,
                                input logic [31:0] e1, e2, ei, input logic [4:0] erd);
        vec_t v;
        v = '{instr: instr, pc: pc, rd1: r1, rd2: r2, ex_wr: exw, ex_ld: exl, ex_rd: exrd,
              ex_res: exres, mem_wr: mw, mem_rd: mrd, mem_res: mres, wb_wr: ww, wb_rd: wrd,
              wb_dat: wd, e_op1: e1, e_op2: e2, e_imm: ei, e_rd: erd};
        return v;
    endfunction

    task automatic set_idle();
        in_valid = 0; flush = 0; out_ready = 1;
        ex_wr_en = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
        mem_wr_en = 0; mem_rd = 0; mem_result = 0;
        wb_wr_en = 0; wb_rd = 0; wb_data = 0;
        rd1 = 0; rd2 = 0; in_instr = 0; in_pc = 0;
    endtask

    vec_t vecs[13];
    logic exp_ready;

    initial begin
        rst = 1;
        set_idle();
        in_valid = 1;
        in_instr = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, T_R);

        vecs[0]  = mk(enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, T_R), 32'h100, 32'd5, 32'd7,
                      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd5, 32'd7, 32'd0, 5'd3);
        vecs[1]  = mk(enc_i(12'd7, 5'd4, 3'd0, 5'd5, T_IMM), 32'h104, 32'h99, 32'h98,
                      1, 0, 4, 32'h11, 1, 4, 32'h22, 1, 4, 32'h33, 32'h11, 32'd0, 32'd7, 5'd5);
        vecs[2]  = mk(enc_i(12'd7, 5'd4, 3'd0, 5'd5, T_IMM), 32'h108, 32'h99, 32'h98,
                      0, 0, 4, 32'h11, 1, 4, 32'h22, 1, 4, 32'h33, 32'h22, 32'd0, 32'd7, 5'd5);
        vecs[3]  = mk(enc_i(12'd7, 5'd4, 3'd0, 5'd5, T_IMM), 32'h10C, 32'h99, 32'h98,
                      0, 0, 4, 32'h11, 0, 4, 32'h22, 1, 4, 32'h33, 32'h33, 32'd0, 32'd7, 5'd5);
        vecs[4]  = mk(enc_i(12'd7, 5'd0, 3'd0, 5'd5, T_IMM), 32'h110, 32'h99, 32'h98,
                      1, 0, 0, 32'h11, 1, 0, 32'h22, 1, 0, 32'h33, 32'd0, 32'd0, 32'd7, 5'd5);
        vecs[5]  = mk(enc_u(20'h12345, 5'd5, T_LUI), 32'h114, 32'hAA, 32'hBB,
                      1, 1, 8, 32'h44, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'h1234_5000, 5'd5);
        vecs[6]  = mk(enc_s(12'hFFC, 5'd2, 5'd1, 3'd2), 32'h118, 32'h100, 32'hBEEF,
                      0, 0, 0, 0, 1, 2, 32'h55, 0, 0, 0, 32'h100, 32'h55, 32'hFFFF_FFFC, 5'd0);
        vecs[7]  = mk(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0), 32'h11C, 32'h1, 32'h22,
                      0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h77, 32'h77, 32'h22, 32'hFFFF_FFF8, 5'd0);
        vecs[8]  = mk(enc_j(21'h800, 5'd1), 32'h120, 32'h33, 32'h44,
                      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'h800, 5'd1);
        vecs[9]  = mk(enc_u(20'h80000, 5'd7, T_AUIPC), 32'h124, 32'h5, 32'h6,
                      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'h8000_0000, 5'd7);
        vecs[10] = mk(enc_i(12'h7FF, 5'd3, 3'd2, 5'd9, T_LOAD), 32'h128, 32'h9, 32'h8,
                      1, 0, 3, 32'h1234, 0, 0, 0, 0, 0, 0, 32'h1234, 32'd0, 32'h7FF, 5'd9);
        vecs[11] = mk(enc_i(12'hFFF, 5'd2, 3'd0, 5'd1, T_JALR), 32'h12C, 32'h50, 32'h66,
                      0, 0, 0, 0, 0, 0, 0, 1, 31, 32'h88, 32'h50, 32'd0, 32'hFFFF_FFFF, 5'd1);
        vecs[12] = mk(enc_r(7'h20, 5'd12, 5'd11, 3'd0, 5'd10, T_R), 32'h130, 32'h100, 32'h30,
                      1, 1, 0, 32'hEE, 1, 12, 32'hAB, 1, 11, 32'hCD, 32'hCD, 32'hAB, 32'd0, 5'd10);

        // ---------------- reset ----------------
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rr1_slice", rr1, 5'd1);
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_op1", out_op1, 0);
        chk("rst_out_imm", out_imm, 0);
        in_valid = 0;
        #1;
        chk("rr2_no_valid", rr2, 5'd2);
        tick();
        rst = 0;

        // ---------------- vector table ----------------
        foreach (vecs[i]) begin
            in_instr = vecs[i].instr; in_pc = vecs[i].pc;
            rd1 = vecs[i].rd1; rd2 = vecs[i].rd2;
            ex_wr_en = vecs[i].ex_wr; ex_is_load = vecs[i].ex_ld;
            ex_rd = vecs[i].ex_rd; ex_result = vecs[i].ex_res;
            mem_wr_en = vecs[i].mem_wr; mem_rd = vecs[i].mem_rd; mem_result = vecs[i].mem_res;
            wb_wr_en = vecs[i].wb_wr; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_dat;
            in_valid = 1; out_ready = 1; flush = 0;
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
            tick();
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_op1", i), out_op1, vecs[i].e_op1);
            chk($sformatf("vec%0d_op2", i), out_op2, vecs[i].e_op2);
            chk($sformatf("vec%0d_imm", i), out_imm, vecs[i].e_imm);
            chk($sformatf("vec%0d_rd", i), out_rd, vecs[i].e_rd);
            chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].pc);
            chk($sformatf("vec%0d_opcode", i), out_opcode, vecs[i].instr[6:0]);
            chk($sformatf("vec%0d_funct3", i), out_funct3, vecs[i].instr[14:12]);
            chk($sformatf("vec%0d_funct7", i), out_funct7, vecs[i].instr[31:25]);
        end

        // ---------------- load-use ----------------
        set_idle();
        in_valid = 1; in_pc = 32'h200;
        in_instr = enc_i(12'd1, 5'd5, 3'd0, 5'd6, T_IMM);
        rd1 = 32'hDEAD;
        ex_wr_en = 1; ex_is_load = 1; ex_rd = 5; ex_result = 32'h999;
        #1;
        chk("lu_stall_ready", in_ready, 0);
        tick();
        chk("lu_bubble_valid", out_valid, 0);
        ex_wr_en = 0; ex_is_load = 0;
        mem_wr_en = 1; mem_rd = 5; mem_result = 32'h40;
        #1;
        chk("lu_release_ready", in_ready, 1);
        tick();
        chk("lu_valid", out_valid, 1);
        chk("lu_op1", out_op1, 32'h40);
        chk("lu_imm", out_imm, 32'd1);
        chk("lu_rd", out_rd, 5'd6);

        // ---------------- back-pressure ----------------
        out_ready = 0; in_valid = 1; in_pc = 32'h204;
        in_instr = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, T_R);
        rd2 = 32'h2222;
        for (int c = 0; c < 3; c++) begin
            rd1 = 32'h1111 + c;
            mem_wr_en = 1; mem_rd = 5; mem_result = 32'h500 + c;
            #1;
            chk($sformatf("bp%0d_in_ready", c), in_ready, 0);
            tick();
            chk($sformatf("bp%0d_valid", c), out_valid, 1);
            chk($sformatf("bp%0d_op1", c), out_op1, 32'h40);
            chk($sformatf("bp%0d_pc", c), out_pc, 32'h200);
            chk($sformatf("bp%0d_rd", c), out_rd, 5'd6);
        end
        out_ready = 1; mem_wr_en = 0; rd1 = 32'h1111;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_op1", out_op1, 32'h1111);
        chk("bp_next_op2", out_op2, 32'h2222);
        chk("bp_next_rd", out_rd, 5'd3);

        // ---------------- flush ----------------
        in_instr = enc_i(12'd7, 5'd1, 3'd0, 5'd8, T_IMM);
        in_pc = 32'h2000; rd1 = 32'h10;
        flush = 1; out_ready = 0; in_valid = 1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        chk("flush_valid", out_valid, 0);
        flush = 0; out_ready = 1;
        #1;
        chk("post_flush_ready", in_ready, 1);
        tick();
        chk("post_flush_valid", out_valid, 1);
        chk("post_flush_rd", out_rd, 5'd8);
        chk("post_flush_op1", out_op1, 32'h10);

        // ---------------- reset during stall ----------------
        out_ready = 0;
        in_instr = enc_r(7'd0, 5'd6, 5'd5, 3'd0, 5'd9, T_R);
        ex_wr_en = 1; ex_is_load = 1; ex_rd = 5;
        #1;
        chk("stall_hold_ready", in_ready, 0);
        tick();
        chk("stall_hold_valid", out_valid, 1);
        rst = 1;
        #1;
        chk("rst2_in_ready", in_ready, 0);
        tick();
        chk("rst2_valid", out_valid, 0);
        chk("rst2_pc", out_pc, 0);
        chk("rst2_op1", out_op1, 0);
        chk("rst2_op2", out_op2, 0);
        chk("rst2_imm", out_imm, 0);
        chk("rst2_rd", out_rd, 0);
        chk("rst2_opcode", out_opcode, 0);
        rst = 0;
        set_idle();

        // ---------------- randomized vs model ----------------
        m_valid = 0; m_pc = 0; m_op1 = 0; m_op2 = 0; m_imm_q = 0;
        m_rd = 0; m_opc = 0; m_f3 = 0; m_f7 = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst        = ($urandom_range(0, 39) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            in_instr   = rand_instr();
            in_pc      = $urandom;
            rd1        = $urandom;
            rd2        = $urandom;
            ex_wr_en   = 1'($urandom_range(0, 1));
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_rd      = 5'($urandom_range(0, 7));
            ex_result  = $urandom;
            mem_wr_en  = 1'($urandom_range(0, 1));
            mem_rd     = 5'($urandom_range(0, 7));
            mem_result = $urandom;
            wb_wr_en   = 1'($urandom_range(0, 1));
            wb_rd      = 5'($urandom_range(0, 7));
            wb_data    = $urandom;
            #1;
            exp_ready = !rst && !flush && (!m_valid || out_ready) && !m_stall();
            chk("rand_in_ready", in_ready, exp_ready);
            chk("rand_rr1", rr1, in_instr[19:15]);
            chk("rand_rr2", rr2, in_instr[24:20]);
            if (rst) begin
                m_valid = 0; m_pc = 0; m_op1 = 0; m_op2 = 0; m_imm_q = 0;
                m_rd = 0; m_opc = 0; m_f3 = 0; m_f7 = 0;
            end else if (flush) begin
                m_valid = 0;
            end else if (in_valid && exp_ready) begin
                m_valid = 1;
                m_pc    = in_pc;
                m_op1   = m_operand(in_instr[19:15], m_uses1(in_instr[6:0]), rd1);
                m_op2   = m_operand(in_instr[24:20], m_uses2(in_instr[6:0]), rd2);
                m_imm_q = m_imm(in_instr);
                m_rd    = (in_instr[6:0] inside {T_STORE, T_BRANCH}) ? 5'd0 : in_instr[11:7];
                m_opc   = in_instr[6:0];
                m_f3    = in_instr[14:12];
                m_f7    = in_instr[31:25];
            end else if (!m_valid || out_ready) begin
                m_valid = 0;
            end
            tick();
            chk("rand_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("rand_pc", out_pc, m_pc);
                chk("rand_op1", out_op1, m_op1);
                chk("rand_op2", out_op2, m_op2);
                chk("rand_imm", out_imm, m_imm_q);
                chk("rand_rd", out_rd, m_rd);
                chk("rand_opcode", out_opcode, m_opc);
                chk("rand_funct3", out_funct3, m_f3);
                chk("rand_funct7", out_funct7, m_f7);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
